sort_engine: RTL and testbench
==============================

Name: sort_engine

Overview:
- Parametrised successor of the 5×4-bit switch-entry sorter.
- Collects DEPTH values of DATA_W bits through a strobe handshake, then sorts them with a fixed-latency odd-even transposition network, one phase per cycle.
- Holds the packed result until the consumer acknowledges it.
- Sits between the debounced switch/confirm front end and the display/readout logic.

Parameters:
DATA_W, 4, width of each element in bits (1..16)
DEPTH, 5, number of elements per sort batch (2..16)
CNT_W, $clog2(DEPTH+1), width of the fill counter (derived, do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_data  input  DATA_W  element value, sampled when in_valid=1 is accepted
in_valid  input  1  single-cycle strobe (debounced confirm), one element per strobe
descend  input  1  sort order, 0=ascending, 1=descending (see Optional Feature)
ack  input  1  consumer has read the result; releases DONE
count  output  CNT_W  number of elements captured in the current batch
busy  output  1  high in SORT
done  output  1  high in DONE
sorted_values  output  DATA_W*DEPTH  packed result, element k at bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset is synchronous: on a rising clk edge with rst=1, all outputs and internal state clear. This gives state=LOAD, count=0, busy=0, done=0, sorted_values=0, element array=0 and phase=0.
- rst=1 overrides every other input on the same edge, including mid-LOAD and mid-SORT. A partial batch is discarded.

FSM:
- LOAD:
  - An in_valid=1 edge writes in_data to array[count] and increments count.
  - If count==DEPTH-1 at that edge, go to SORT with phase=0. count reads DEPTH while in SORT/DONE.
- SORT:
  - Runs exactly DEPTH cycles, phase 0..DEPTH-1.
  - Even phase compares pairs (0,1),(2,3),…; odd phase compares pairs (1,2),(3,4),…. All pairs in a phase are compared in parallel.
  - Ascending: swap if array[j] > array[j+1]. Descending: swap if array[j] < array[j+1]. Comparison is unsigned and strict, so equal values never swap.
  - descend is sampled once, on the edge that captures the last element. Changes during SORT are ignored.
  - On the edge that executes phase DEPTH-1: load sorted_values with the post-phase array, then go to DONE.
- DONE:
  - done=1. sorted_values stays stable.
  - An ack=1 edge goes to LOAD with count=0 and done=0. sorted_values is kept until the next DONE entry or rst.

Latency:
- done rises DEPTH edges after the edge that accepted the last element.
- Example: DEPTH=5, last capture at edge T gives done=1 after edge T+5.

Boundary conditions:
- in_valid in SORT or DONE is ignored: no capture, count unchanged.
- ack outside DONE is ignored.
- in_valid and ack on the same DONE edge: ack is taken and the element is dropped. The new batch starts on the next in_valid.
- Back-to-back in_valid every cycle is legal. A full batch loads in DEPTH cycles.
- count never exceeds DEPTH and never wraps.
- DEPTH odd or even both produce a fully sorted result in DEPTH phases.

Optional Feature:
SORT_DESC_EN
- Defined: descend port is functional as above.
- Undefined: descend is ignored, order is always ascending, and no descend-dependent logic is synthesised. The port remains present for pin compatibility.

Test Plan:
- DATA_W=4, DEPTH=5, descend=0, strobe 9,3,7,3,0 on consecutive cycles -> done after 5 edges, sorted_values=20'h97330 (element0=0 … element4=9), count=5, busy high exactly 5 cycles.
- Same data, descend=1 (SORT_DESC_EN defined) -> sorted_values=20'h03379. Same data, descend=1 with macro undefined -> 20'h97330.
- Capture 3 values, assert rst for 1 cycle, then strobe F,E,D,C,B -> count returns to 0 after reset, result 20'hFEDCB, earlier values absent.
- In DONE, hold in_valid with in_data=A for 4 cycles without ack -> sorted_values and count unchanged. Then pulse ack -> done=0, count=0 next cycle, old sorted_values still visible.
- Pulse rst during SORT phase 2 -> next cycle busy=0, done=0, count=0, sorted_values=0.
- DEPTH=4, DATA_W=8, input 8'hFF,8'h00,8'h80,8'h80 -> done 4 edges after last capture, sorted_values=32'hFF808000.

Source files
------------

// File: rtl/sort_engine.sv
// Batch sorter: captures DEPTH elements by strobe, sorts them with an odd-even transposition network (one phase per cycle), holds the result until ack.
// Optional macro SORT_DESC_EN enables the descend input; without it the order is always ascending.
module sort_engine #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 5,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    descend,
    input  logic                    ack,
    output logic [CNT_W-1:0]        count,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W*DEPTH-1:0] sorted_values
);

    localparam int PH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [DATA_W-1:0]        r_arr [DEPTH];
    logic [PH_W-1:0]          r_phase;
    logic [CNT_W-1:0]         r_count;
    logic                     r_busy;
    logic                     r_done;
    logic [DATA_W*DEPTH-1:0]  r_sorted;

    logic [DATA_W-1:0]        w_next [DEPTH];
    logic [DATA_W*DEPTH-1:0]  w_pack;
    logic [DEPTH-2:0]         w_swap;

`ifdef SORT_DESC_EN
    logic                     r_desc;
`else
    logic                     w_unused_descend;
    assign w_unused_descend = descend;
`endif

    // Pair j is active when its lower index parity matches the current phase parity.
    for (genvar j = 0; j < DEPTH - 1; j++) begin : g_pair
        logic w_cond;
`ifdef SORT_DESC_EN
        assign w_cond = r_desc ? (r_arr[j] < r_arr[j+1]) : (r_arr[j] > r_arr[j+1]);
`else
        assign w_cond = (r_arr[j] > r_arr[j+1]);
`endif
        assign w_swap[j] = w_cond && (r_phase[0] == 1'(j % 2));
    end

    // Active pairs in one phase are disjoint, so each element takes at most one neighbour.
    for (genvar k = 0; k < DEPTH; k++) begin : g_elem
        if (k == 0) begin : g_first
            assign w_next[k] = w_swap[0] ? r_arr[1] : r_arr[0];
        end else if (k == DEPTH - 1) begin : g_last
            assign w_next[k] = w_swap[k-1] ? r_arr[k-1] : r_arr[k];
        end else begin : g_mid
            assign w_next[k] = w_swap[k]   ? r_arr[k+1] :
                               w_swap[k-1] ? r_arr[k-1] : r_arr[k];
        end
        assign w_pack[k*DATA_W +: DATA_W] = w_next[k];
    end

    // Control FSM, element storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_LOAD;
            r_phase  <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sorted <= '0;
`ifdef SORT_DESC_EN
            r_desc   <= 1'b0;
`endif
            for (int k = 0; k < DEPTH; k++) begin
                r_arr[k] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (r_count == CNT_W'(k)) begin
                                r_arr[k] <= in_data;
                            end
                        end
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(DEPTH - 1)) begin
                            r_state <= S_SORT;
                            r_phase <= '0;
                            r_busy  <= 1'b1;
`ifdef SORT_DESC_EN
                            r_desc  <= descend;
`endif
                        end
                    end
                end
                S_SORT: begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_arr[k] <= w_next[k];
                    end
                    if (r_phase == PH_W'(DEPTH - 1)) begin
                        r_sorted <= w_pack;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_phase  <= '0;
                    end else begin
                        r_phase  <= r_phase + PH_W'(1);
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_state <= S_LOAD;
                        r_count <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_phase <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign count         = r_count;
    assign busy          = r_busy;
    assign done          = r_done;
    assign sorted_values = r_sorted;

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: a 4x5 instance and an 8x4 instance, with a scoreboard of expected packed results.
module tb_sort_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  d5;
    logic        v5, desc5, ack5;
    logic [2:0]  cnt5;
    logic        busy5, done5;
    logic [19:0] sv5;

    logic [7:0]  d4;
    logic        v4, desc4, ack4;
    logic [2:0]  cnt4;
    logic        busy4, done4;
    logic [31:0] sv4;

    int vec  = 0;
    int errs = 0;
    logic [63:0] sb_q [$];

    sort_engine #(.DATA_W(4), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(d5), .in_valid(v5), .descend(desc5), .ack(ack5),
        .count(cnt5), .busy(busy5), .done(done5), .sorted_values(sv5)
    );

    sort_engine #(.DATA_W(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .descend(desc4), .ack(ack4),
        .count(cnt4), .busy(busy4), .done(done4), .sorted_values(sv4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int which, output int edges, output int bc);
        edges = 0;
        bc    = 0;
        while (((which == 0) ? done5 : done4) !== 1'b1 && edges < 40) begin
            if (((which == 0) ? busy5 : busy4) === 1'b1) bc++;
            tick();
            edges++;
        end
    endtask

    task automatic load5(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] e);
        logic [3:0] vals [5];
        vals = '{a, b, c, d, e};
        for (int i = 0; i < 5; i++) begin
            d5 = vals[i];
            v5 = 1'b1;
            tick();
            if (i < 4) chk("load_count", 64'(cnt5), 64'(i + 1));
        end
        v5 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int edges, bc;
        logic [63:0] exp;
        rst = 1'b1; d5 = 4'h0; v5 = 1'b0; desc5 = 1'b0; ack5 = 1'b0;
        d4 = 8'h00; v4 = 1'b0; desc4 = 1'b0; ack4 = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_count", 64'(cnt5), 64'd0);
        chk("rst_busy", 64'(busy5), 64'd0);
        chk("rst_done", 64'(done5), 64'd0);
        chk("rst_sorted", 64'(sv5), 64'd0);

        // Batch 1 ascending; in_valid held with data A through SORT and DONE must be ignored.
        ack5 = 1'b1;
        tick();
        ack5 = 1'b0;
        chk("ack_in_load", 64'(cnt5), 64'd0);
        sb_q.push_back(64'h97330);
        load5(4'h9, 4'h3, 4'h7, 4'h3, 4'h0);
        chk("sort_busy", 64'(busy5), 64'd1);
        chk("sort_count", 64'(cnt5), 64'd5);
        d5 = 4'hA;
        v5 = 1'b1;
        wait_done(0, edges, bc);
        chk("lat1", 64'(edges), 64'd5);
        chk("busy_cycles", 64'(bc), 64'd5);
        exp = sb_q.pop_front();
        chk("sorted_asc", 64'(sv5), exp);
        chk("done_count", 64'(cnt5), 64'd5);
        chk("done_busy", 64'(busy5), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_sorted", 64'(sv5), exp);
            chk("hold_count", 64'(cnt5), 64'd5);
            chk("hold_done", 64'(done5), 64'd1);
        end
        ack5 = 1'b1;
        tick();
        ack5 = 1'b0;
        v5 = 1'b0;
        chk("ack_done", 64'(done5), 64'd0);
        chk("ack_count", 64'(cnt5), 64'd0);
        chk("ack_keep", 64'(sv5), exp);

        // Batch 2: descend sampled on last capture, flipped and ack held during SORT.
`ifdef SORT_DESC_EN
        sb_q.push_back(64'h03379);
`else
        sb_q.push_back(64'h97330);
`endif
        desc5 = 1'b1;
        load5(4'h9, 4'h3, 4'h7, 4'h3, 4'h0);
        desc5 = 1'b0;
        ack5 = 1'b1;
        wait_done(0, edges, bc);
        ack5 = 1'b0;
        chk("lat2", 64'(edges), 64'd5);
        exp = sb_q.pop_front();
        chk("sorted_desc", 64'(sv5), exp);
        ack5 = 1'b1;
        tick();
        ack5 = 1'b0;

        // Partial batch discarded by reset.
        for (int i = 0; i < 3; i++) begin
            d5 = 4'(i + 1);
            v5 = 1'b1;
            tick();
        end
        v5 = 1'b0;
        chk("partial_count", 64'(cnt5), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("partial_rst", 64'(cnt5), 64'd0);
        sb_q.push_back(64'hFEDCB);
        load5(4'hF, 4'hE, 4'hD, 4'hC, 4'hB);
        wait_done(0, edges, bc);
        chk("lat3", 64'(edges), 64'd5);
        exp = sb_q.pop_front();
        chk("sorted_fedcb", 64'(sv5), exp);
        ack5 = 1'b1;
        tick();
        ack5 = 1'b0;

        // Reset while phase 2 is pending.
        load5(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        tick();
        tick();
        chk("mid_busy_pre", 64'(busy5), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", 64'(busy5), 64'd0);
        chk("mid_done", 64'(done5), 64'd0);
        chk("mid_count", 64'(cnt5), 64'd0);
        chk("mid_sorted", 64'(sv5), 64'd0);

        // 8-bit, 4-deep instance with equal values.
        sb_q.push_back(64'hFF808000);
        begin
            logic [7:0] v8 [4];
            v8 = '{8'hFF, 8'h00, 8'h80, 8'h80};
            for (int i = 0; i < 4; i++) begin
                d4 = v8[i];
                v4 = 1'b1;
                tick();
            end
            v4 = 1'b0;
        end
        chk("d4_count", 64'(cnt4), 64'd4);
        wait_done(1, edges, bc);
        chk("d4_lat", 64'(edges), 64'd4);
        chk("d4_busy_cycles", 64'(bc), 64'd4);
        exp = sb_q.pop_front();
        chk("d4_sorted", 64'(sv4), exp);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
